// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary weight unpacker: trit codes, FSM states,
// the default tile marker and the base-3 digit to weight-code mapping.
package ternary_pkg;

    // Weight codes seen by the systolic array: bit1 is the sign, 00 is zero
    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b11;

    localparam logic [7:0] DEFAULT_MARKER  = 8'hFF;
    localparam logic [7:0] FIRST_INVALID   = 8'd243;
    localparam int         TRITS_PER_BYTE  = 5;
    localparam int         TRITS_PER_GROUP = 4;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } state_e;

    // Base-3 digit 0/1/2 maps to weight 0/+1/-1
    function automatic logic [1:0] digit_to_code(input logic [1:0] digit);
        logic [1:0] code;
        case (digit)
            2'd1:    code = W_POS;
            2'd2:    code = W_NEG;
            default: code = W_ZERO;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ternary_weight_unpacker_decoder.sv
// Combinational base-3 unpacker: one byte becomes five 2-bit weight codes,
// least significant digit first, plus a flag for the unused range 243..255.
module ternary_byte_decoder
    import ternary_pkg::*;
(
    input  logic [7:0] data,
    output logic [9:0] codes,
    output logic       is_invalid
);

    logic [7:0] rem;

    // Peel digits off with a repeated divide-by-3 chain
    always_comb begin
        rem   = data;
        codes = '0;
        for (int k = 0; k < TRITS_PER_BYTE; k++) begin
            codes[2*k +: 2] = digit_to_code(2'(rem % 8'd3));
            rem             = rem / 8'd3;
        end
    end

    assign is_invalid = (data >= FIRST_INVALID);

endmodule

// File: rtl/ternary_weight_unpacker.sv
// Packed 5-trit bytes in, 4-weight groups out, through a trit FIFO with
// valid/ready on both sides. Build option: TERNARY_UNPACK_PIPE_EN.
module ternary_weight_unpacker
    import ternary_pkg::*;
#(
    parameter int         BUF_TRITS = 12,
    parameter logic [7:0] MARKER    = DEFAULT_MARKER
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_weights,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       tile_done,
    output logic       err_invalid
);

    localparam int BW = 2 * BUF_TRITS;
    localparam int CW = $clog2(BUF_TRITS + 1);

    // Trit i lives at tbuf[2i+1:2i]; slots at or above count are kept zero,
    // so a short final group is already zero-padded.
    state_e        state;
    state_e        state_n;
    logic [BW-1:0] tbuf;
    logic [BW-1:0] tbuf_n;
    logic [CW-1:0] count;
    logic [CW-1:0] count_n;
    logic          err_q;

    logic [9:0]    dec_codes;
    logic          dec_invalid;
    logic          dec_marker;

    logic          accept;
    logic          land_valid;
    logic          land_marker;
    logic          land_invalid;
    logic [9:0]    land_codes;

    logic          pop;
    logic          push;
    int            taken;
    int            base;
    logic [BW-1:0] shifted;
    logic [BW-1:0] ins;

    ternary_byte_decoder u_decoder (
        .data       (in_byte),
        .codes      (dec_codes),
        .is_invalid (dec_invalid)
    );

    assign dec_marker = (in_byte == MARKER);
    assign accept     = in_valid && in_ready;

`ifdef TERNARY_UNPACK_PIPE_EN
    logic       pipe_valid;
    logic       pipe_marker;
    logic       pipe_invalid;
    logic [9:0] pipe_codes;

    // Space is reserved for a byte still in flight; a queued marker
    // blocks further input so nothing can slip in behind the tile end.
    assign in_ready = !reset && (state == RUN)
                      && !(pipe_valid && pipe_marker)
                      && (int'(count) + (pipe_valid ? TRITS_PER_BYTE : 0)
                          + TRITS_PER_BYTE <= BUF_TRITS);

    // Decoder-to-buffer register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid   <= 1'b0;
            pipe_marker  <= 1'b0;
            pipe_invalid <= 1'b0;
            pipe_codes   <= '0;
        end else begin
            pipe_valid   <= accept;
            pipe_marker  <= dec_marker;
            pipe_invalid <= dec_invalid && !dec_marker;
            pipe_codes   <= dec_codes;
        end
    end

    assign land_valid   = pipe_valid;
    assign land_marker  = pipe_marker;
    assign land_invalid = pipe_invalid;
    assign land_codes   = pipe_codes;
`else
    // Only registered count is used: no path from out_ready to in_ready
    assign in_ready = !reset && (state == RUN)
                      && (int'(count) + TRITS_PER_BYTE <= BUF_TRITS);

    assign land_valid   = accept;
    assign land_marker  = dec_marker;
    assign land_invalid = dec_invalid && !dec_marker;
    assign land_codes   = dec_codes;
`endif

    // Output group is valid on a full group, or any residue while draining
    always_comb begin
        out_valid = 1'b0;
        unique case (state)
            RUN:     out_valid = (int'(count) >= TRITS_PER_GROUP);
            DRAIN:   out_valid = (count != '0);
            default: out_valid = 1'b0;
        endcase
    end

    assign out_weights = out_valid ? tbuf[7:0] : 8'h00;
    assign tile_done   = (state == DONE);
    assign err_invalid = err_q;

    // FIFO update: pop the head group, then append new trits behind survivors
    always_comb begin
        pop     = out_valid && out_ready;
        push    = land_valid && !land_marker && !land_invalid;
        taken   = 0;
        if (pop) begin
            taken = (int'(count) >= TRITS_PER_GROUP) ? TRITS_PER_GROUP
                                                     : int'(count);
        end
        base    = int'(count) - taken;
        shifted = pop ? (tbuf >> (2 * TRITS_PER_GROUP)) : tbuf;
        ins     = '0;
        if (push) begin
            ins = BW'(land_codes) << (2 * base);
        end
        tbuf_n  = shifted | ins;
        count_n = CW'(base + (push ? TRITS_PER_BYTE : 0));
    end

    // Tile sequencing: marker starts the drain, empty buffer ends it
    always_comb begin
        state_n = state;
        unique case (state)
            RUN:     if (land_valid && land_marker) state_n = DRAIN;
            DRAIN:   if (count == '0) state_n = DONE;
            DONE:    state_n = RUN;
            default: state_n = RUN;
        endcase
    end

    // State, buffer and sticky error registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            tbuf  <= '0;
            count <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            tbuf  <= tbuf_n;
            count <= count_n;
            err_q <= err_q || (land_valid && land_invalid);
        end
    end

endmodule

// File: tb/tb_ternary_weight_unpacker.sv
// Scoreboard bench for ternary_weight_unpacker: a trit-list reference model
// queues expected groups; a monitor checks every output handshake.
module tb_ternary_weight_unpacker;

    localparam int         BUF = 12;
    localparam logic [7:0] MK  = 8'hFF;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_weights;
    logic       out_valid;
    logic       out_ready;
    logic       tile_done;
    logic       err_invalid;

    ternary_weight_unpacker #(
        .BUF_TRITS (BUF),
        .MARKER    (MK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_weights (out_weights),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .tile_done   (tile_done),
        .err_invalid (err_invalid)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] exp_q[$];
    int         grp_n[$];
    int         pend[$];
    int         occ = 0;
    int         exp_tiles = 0;
    int         got_tiles = 0;
    bit         exp_err = 1'b0;
    bit         exp_err_next = 1'b0;
    int         rdy_pct = 100;
    bit         stall_prev = 1'b0;
    logic [7:0] hold_w = 8'h00;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    function automatic logic [1:0] enc(input int t);
        if (t == 0) return 2'b00;
        return (t > 0) ? 2'b01 : 2'b11;
    endfunction

    // Cut the pending trit list into groups of four; pad a short tail on demand
    function automatic void make_groups(input bit pad);
        logic [7:0] g;
        int         n;
        while (pend.size() >= 4 || (pad && pend.size() > 0)) begin
            g = 8'h00;
            n = (pend.size() < 4) ? pend.size() : 4;
            for (int k = 0; k < n; k++) g[2*k +: 2] = enc(pend.pop_front());
            exp_q.push_back(g);
            grp_n.push_back(n);
        end
    endfunction

    function automatic void model_accept(input logic [7:0] b);
        int v;
        int d;
        if (b == MK) begin
            make_groups(1'b1);
            exp_tiles++;
        end else if (b >= 8'd243) begin
            exp_err_next = 1'b1;
        end else begin
            v = int'(b);
            for (int k = 0; k < 5; k++) begin
                d = v % 3;
                pend.push_back((d == 2) ? -1 : d);
                v = v / 3;
            end
            occ += 5;
            make_groups(1'b0);
        end
    endfunction

    task automatic send(input logic [7:0] b);
        int w;
        w = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        #1;
        while (!in_ready && w < 400) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("in_ready_wait", int'(in_ready), 1);
        if (in_ready) begin
            check("no_overflow", int'(occ + 5 <= BUF), 1);
            model_accept(b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((exp_q.size() != 0 || got_tiles != exp_tiles) && i < 500) begin
            @(negedge clk);
            #3;
            i++;
        end
        check("drain_groups", exp_q.size(), 0);
        check("drain_tiles", got_tiles, exp_tiles);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        grp_n.delete();
        pend.delete();
        occ          = 0;
        exp_err      = 1'b0;
        exp_err_next = 1'b0;
        repeat (cycles) @(negedge clk);
        exp_tiles = got_tiles;
        reset     = 1'b0;
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            out_ready = (rdy_pct >= 100) ? 1'b1
                      : (int'($urandom_range(99)) < rdy_pct);
        end
    end

    always @(negedge clk) begin
        #2;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("hold_weights", int'({out_valid, out_weights}),
                      int'({1'b1, hold_w}));
            if (!out_valid) check("idle_zero", int'(out_weights), 0);
            if (out_valid && out_ready) begin
                check("group_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("group_value", int'(out_weights), int'(exp_q.pop_front()));
                    occ -= grp_n.pop_front();
                end
            end
            if (tile_done) begin
                got_tiles++;
                check("tile_after_drain", exp_q.size(), 0);
            end
            check("err_flag", int'(err_invalid), int'(exp_err));
            exp_err    = exp_err_next;
            stall_prev = out_valid && !out_ready;
            hold_w     = out_weights;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         n;
        int         r;
        logic [7:0] b;
        time        t0;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_weights", int'(out_weights), 0);
        check("rst_tile_done", int'(tile_done), 0);
        check("rst_err", int'(err_invalid), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);

        // All +1 byte: one group, one trit left so no second group
        rdy_pct = 100;
        send(8'd121);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("t1_residue_not_valid", int'(out_valid), 0);
        send(MK);
        drain();

        // Byte 7 then marker: group plus padded tail, input closed while draining
        send(8'd7);
        send(MK);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            #1;
            n++;
            if (tile_done) break;
            check("drain_in_ready", int'(in_ready), 0);
        end
        check("t2_tile_seen", int'(tile_done), 1);
        drain();

        // Marker on an empty buffer
        send(MK);
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            #2;
            n++;
            if (tile_done) break;
        end
        check("empty_marker_latency", n, 2);
        drain();

        // Four 242s back to back with the output always ready
        t0 = $time;
        repeat (4) send(8'd242);
        check("t3_back_to_back", int'(($time - t0) / 10), 4);
        drain();

        // Output stalled: buffer fills and head group holds
        rdy_pct = 0;
        send(8'd121);
        send(8'd121);
        repeat (10) begin
            @(negedge clk);
            #1;
            check("full_in_ready", int'(in_ready), 0);
            check("stall_weights", int'(out_weights), 8'h55);
        end
        rdy_pct = 100;
        drain();

        // Invalid byte: no trits, sticky error
        send(8'd250);
        send(8'd121);
        send(8'd121);
        drain();
        repeat (3) @(negedge clk);
        #1;
        check("err_sticky", int'(err_invalid), 1);

        // Random traffic with random backpressure
        for (int seg = 0; seg < 6; seg++) begin
            rdy_pct = 30 + int'($urandom_range(70));
            for (int i = 0; i < 40; i++) begin
                r = int'($urandom_range(99));
                if (r < 5)       b = MK;
                else if (r < 10) b = 8'(243 + $urandom_range(11));
                else             b = 8'($urandom_range(242));
                send(b);
                if ($urandom_range(3) == 0) @(negedge clk);
            end
        end
        rdy_pct = 100;
        send(MK);
        drain();

        // Reset while draining with six trits held
        rdy_pct = 0;
        send(8'd121);
        send(8'd121);
        rdy_pct = 100;
        n = 0;
        while (occ > 6 && n < 50) begin
            @(negedge clk);
            #3;
            n++;
        end
        rdy_pct = 0;
        check("t6_one_pop", occ, 6);
        send(MK);
        do_reset(1);
        #2;
        check("t6_out_valid", int'(out_valid), 0);
        check("t6_tile_done", int'(tile_done), 0);
        check("t6_in_ready", int'(in_ready), 1);
        rdy_pct = 100;
        repeat (6) begin
            @(negedge clk);
            #1;
            check("t6_no_tile", int'(tile_done), 0);
            check("t6_empty", int'(out_valid), 0);
        end
        check("final_err_clear", int'(err_invalid), 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
